// File: rtl/altera_tse_pcs_tx_ordered_set_gen.sv
// Clause-36 style PCS transmit ordered-set generator: turns GMII octets into
// idle, config, start/end/extend and error code-group requests for the 8b/10b encoder.
module altera_tse_pcs_tx_ordered_set_gen #(
  parameter int ENABLE_SGMII = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  gmii_tx_d,
  input  logic        gmii_tx_en,
  input  logic        gmii_tx_err,
  input  logic        xmit_data,
  input  logic [15:0] tx_config_reg,
  input  logic        tx_rd_pos,
  output logic [7:0]  tx_frame,
  output logic        tx_kchar,
  output logic        tx_even,
  output logic        tx_busy
);

  localparam logic [2:0] IDLE_K = 3'd0;
  localparam logic [2:0] IDLE_D = 3'd1;
  localparam logic [2:0] CFG    = 3'd2;
  localparam logic [2:0] SOP    = 3'd3;
  localparam logic [2:0] DATA   = 3'd4;
  localparam logic [2:0] EOP_T  = 3'd5;
  localparam logic [2:0] EOP_R1 = 3'd6;
  localparam logic [2:0] EOP_R2 = 3'd7;

  localparam logic [7:0] K28_5  = 8'hBC;
  localparam logic [7:0] D5_6   = 8'hC5;
  localparam logic [7:0] D16_2  = 8'h50;
  localparam logic [7:0] D21_5  = 8'hB5;
  localparam logic [7:0] D2_2   = 8'h42;
  localparam logic [7:0] CODE_S = 8'hFB;
  localparam logic [7:0] CODE_T = 8'hFD;
  localparam logic [7:0] CODE_R = 8'hF7;
  localparam logic [7:0] CODE_V = 8'hFE;

  // 1000BASE-X never advertises bit 0 in the config word; SGMII passes it through.
  localparam logic [15:0] CFG_MASK = (ENABLE_SGMII != 0) ? 16'hFFFF : 16'hFFFE;

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic [2:0]  cfg_slot;
  logic [2:0]  next_slot;
  logic        load_cfg;
  logic [15:0] cfg_word;
  logic [7:0]  d_q;
  logic        en_q;
  logic        err_q;
  logic [7:0]  next_frame;
  logic        next_kchar;
  logic        next_busy;

  // Every even slot boundary is a decision point: config, frame start or idle.
  always_comb begin
    next_state = state;
    next_slot  = cfg_slot;
    load_cfg   = 1'b0;
    case (state)
      IDLE_K: next_state = IDLE_D;
      IDLE_D: begin
        if (!xmit_data) begin
          next_state = CFG;
          next_slot  = 3'd0;
          load_cfg   = 1'b1;
        end else if (en_q) begin
          next_state = SOP;
        end else begin
          next_state = IDLE_K;
        end
      end
      CFG: begin
        if (cfg_slot[1:0] == 2'd3 && xmit_data) begin
          next_state = IDLE_K;
        end else begin
          next_slot = cfg_slot + 3'd1;
          load_cfg  = (cfg_slot == 3'd7);
        end
      end
      SOP, DATA: begin
        if (xmit_data && en_q) next_state = DATA;
        else                   next_state = EOP_T;
      end
      EOP_T: next_state = EOP_R1;
      EOP_R1: begin
        if (tx_even) begin
          next_state = EOP_R2;
        end else if (!xmit_data) begin
          next_state = CFG;
          next_slot  = 3'd0;
          load_cfg   = 1'b1;
        end else begin
          next_state = IDLE_K;
        end
      end
      EOP_R2: begin
        if (!xmit_data) begin
          next_state = CFG;
          next_slot  = 3'd0;
          load_cfg   = 1'b1;
        end else begin
          next_state = IDLE_K;
        end
      end
      default: next_state = IDLE_K;
    endcase
  end

  always_comb begin
    next_frame = K28_5;
    next_kchar = 1'b1;
    next_busy  = 1'b0;
    case (next_state)
      IDLE_K: next_frame = K28_5;
      IDLE_D: begin
        next_kchar = 1'b0;
        next_frame = tx_rd_pos ? D5_6 : D16_2;
      end
      CFG: begin
        case (next_slot[1:0])
          2'd0: next_frame = K28_5;
          2'd1: begin
            next_kchar = 1'b0;
            next_frame = next_slot[2] ? D2_2 : D21_5;
          end
          2'd2: begin
            next_kchar = 1'b0;
            next_frame = cfg_word[7:0];
          end
          default: begin
            next_kchar = 1'b0;
            next_frame = cfg_word[15:8];
          end
        endcase
      end
      SOP: begin
        next_busy  = 1'b1;
        next_frame = CODE_S;
      end
      DATA: begin
        next_busy = 1'b1;
        if (err_q) begin
          next_frame = CODE_V;
        end else begin
          next_kchar = 1'b0;
          next_frame = d_q;
        end
      end
      EOP_T: begin
        next_busy  = 1'b1;
        next_frame = CODE_T;
      end
      default: begin
        next_busy  = 1'b1;
        next_frame = CODE_R;
      end
    endcase
  end

  // GMII is registered once so each octet lands one slot later, letting the
  // start-of-frame decision see the octet it replaces with /S/.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_q      <= 8'h00;
      en_q     <= 1'b0;
      err_q    <= 1'b0;
      state    <= IDLE_K;
      cfg_slot <= 3'd0;
      cfg_word <= 16'h0000;
      tx_frame <= K28_5;
      tx_kchar <= 1'b1;
      tx_even  <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      d_q      <= gmii_tx_d;
      en_q     <= gmii_tx_en;
      err_q    <= gmii_tx_err;
      state    <= next_state;
      cfg_slot <= next_slot;
      if (load_cfg) cfg_word <= tx_config_reg & CFG_MASK;
      tx_frame <= next_frame;
      tx_kchar <= next_kchar;
      tx_even  <= ~tx_even;
      tx_busy  <= next_busy;
    end
  end

endmodule

// File: tb/tb_altera_tse_pcs_tx_ordered_set_gen.sv
// Scoreboard bench for the PCS transmit ordered-set generator; an SGMII and a
// 1000BASE-X instance share stimulus and are checked against hand-derived code groups.
module tb_altera_tse_pcs_tx_ordered_set_gen;

  typedef struct {
    int         cyc;
    logic [7:0] frame;
    logic       k;
    logic       even;
    logic       busy;
    string      name;
  } exp_t;

  localparam logic [7:0] BC = 8'hBC;
  localparam logic [7:0] C5 = 8'hC5;
  localparam logic [7:0] D50 = 8'h50;
  localparam logic [7:0] FB = 8'hFB;
  localparam logic [7:0] FD = 8'hFD;
  localparam logic [7:0] F7 = 8'hF7;
  localparam logic [7:0] FE = 8'hFE;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  gmii_tx_d;
  logic        gmii_tx_en;
  logic        gmii_tx_err;
  logic        xmit_data;
  logic [15:0] tx_config_reg;
  logic        tx_rd_pos;
  logic [7:0]  frame0, frame1;
  logic        k0, k1, even0, even1, busy0, busy1;

  int   cyc = 0;
  int   vec_count = 0;
  int   err_count = 0;
  logic exp_even = 1'b1;
  exp_t q0[$];
  exp_t q1[$];
  exp_t mon_e;

  logic [7:0] oct [10] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'hA1, 8'hA2};
  logic [7:0] cfg_a [8] = '{8'hBC, 8'hB5, 8'hA0, 8'h01, 8'hBC, 8'h42, 8'hA0, 8'h01};
  logic [7:0] cfg_b0 [8] = '{8'hBC, 8'hB5, 8'h21, 8'h00, 8'hBC, 8'h42, 8'h21, 8'h00};
  logic [7:0] cfg_b1 [8] = '{8'hBC, 8'hB5, 8'h20, 8'h00, 8'hBC, 8'h42, 8'h20, 8'h00};
  logic       cfg_k [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  altera_tse_pcs_tx_ordered_set_gen #(.ENABLE_SGMII(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .gmii_tx_d(gmii_tx_d), .gmii_tx_en(gmii_tx_en),
    .gmii_tx_err(gmii_tx_err), .xmit_data(xmit_data), .tx_config_reg(tx_config_reg),
    .tx_rd_pos(tx_rd_pos), .tx_frame(frame0), .tx_kchar(k0), .tx_even(even0), .tx_busy(busy0)
  );

  altera_tse_pcs_tx_ordered_set_gen #(.ENABLE_SGMII(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .gmii_tx_d(gmii_tx_d), .gmii_tx_en(gmii_tx_en),
    .gmii_tx_err(gmii_tx_err), .xmit_data(xmit_data), .tx_config_reg(tx_config_reg),
    .tx_rd_pos(tx_rd_pos), .tx_frame(frame1), .tx_kchar(k1), .tx_even(even1), .tx_busy(busy1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input exp_t e, input string tag, input logic [7:0] f,
                             input logic k, input logic ev, input logic b);
    vec_count++;
    if ({f, k, ev, b} !== {e.frame, e.k, e.even, e.busy}) begin
      err_count++;
      $display("[TB] FAIL %s/%s cyc=%0d: got frame=%h k=%b even=%b busy=%b, expected frame=%h k=%b even=%b busy=%b",
               tag, e.name, cyc, f, k, ev, b, e.frame, e.k, e.even, e.busy);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    while (q0.size() != 0 && q0[0].cyc <= cyc) begin
      mon_e = q0.pop_front();
      if (mon_e.cyc < cyc) begin
        vec_count++;
        err_count++;
        $display("[TB] FAIL dut0/%s: expectation for cyc %0d never checked (now %0d)", mon_e.name, mon_e.cyc, cyc);
      end else begin
        checkOutput(mon_e, "dut0", frame0, k0, even0, busy0);
      end
    end
    while (q1.size() != 0 && q1[0].cyc <= cyc) begin
      mon_e = q1.pop_front();
      if (mon_e.cyc < cyc) begin
        vec_count++;
        err_count++;
        $display("[TB] FAIL dut1/%s: expectation for cyc %0d never checked (now %0d)", mon_e.name, mon_e.cyc, cyc);
      end else begin
        checkOutput(mon_e, "dut1", frame1, k1, even1, busy1);
      end
    end
  end

  task automatic pushExp(input int c, input logic [7:0] ef, input logic [7:0] ef1,
                         input logic ek, input logic eb, input string nm);
    exp_t e;
    e.cyc = c;
    e.frame = ef;
    e.k = ek;
    e.even = exp_even;
    e.busy = eb;
    e.name = nm;
    q0.push_back(e);
    e.frame = ef1;
    q1.push_back(e);
  endtask

  // Inputs are driven 1ns after an edge; the expectation is for the output after the next edge.
  task automatic driveStep(input logic rst, input logic xm, input logic rd, input logic en,
                           input logic [7:0] d, input logic err, input bit chk,
                           input logic [7:0] ef, input logic [7:0] ef1,
                           input logic ek, input logic eb, input string nm);
    @(posedge clk);
    #1;
    reset_n = rst;
    xmit_data = xm;
    tx_rd_pos = rd;
    gmii_tx_en = en;
    gmii_tx_d = d;
    gmii_tx_err = err;
    exp_even = rst ? ~exp_even : 1'b1;
    if (chk) pushExp(cyc + 1, ef, ef1, ek, eb, nm);
  endtask

  task automatic applyStimulus(input logic rst, input logic xm, input logic rd, input logic en,
                               input logic [7:0] d, input logic err,
                               input logic [7:0] ef, input logic ek, input logic eb, input string nm);
    driveStep(rst, xm, rd, en, d, err, 1'b1, ef, ef, ek, eb, nm);
  endtask

  task automatic assertResetNow();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    gmii_tx_en = 1'b0;
    exp_even = 1'b1;
    pushExp(cyc, BC, BC, 1'b1, 1'b0, "async_reset");
    pushExp(cyc + 1, BC, BC, 1'b1, 1'b0, "reset_held");
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] ef;
    logic       ek;
    logic       eb;
    reset_n = 1'b0;
    gmii_tx_d = 8'h00;
    gmii_tx_en = 1'b0;
    gmii_tx_err = 1'b0;
    xmit_data = 1'b1;
    tx_config_reg = 16'h0000;
    tx_rd_pos = 1'b0;

    // Reset and plain idle stream
    repeat (3) applyStimulus(0, 1, 0, 0, 8'h00, 0, BC, 1, 0, "reset_hold");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 0, 8'h00, 0, D50, 0, 0, "idle_d");
      applyStimulus(1, 1, 0, 0, 8'h00, 0, BC, 1, 0, "idle_k");
    end

    // Frame whose first octet lands in an even slot: /S/ replaces it
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin ef = D50; ek = 0; eb = 0; end
      else if (i == 1) begin ef = FB; ek = 1; eb = 1; end
      else begin ef = oct[i-1]; ek = 0; eb = 1; end
      applyStimulus(1, 1, 0, 1, oct[i], 0, ef, ek, eb, "even_start");
    end
    applyStimulus(1, 1, 0, 0, 8'h00, 0, 8'hA2, 0, 1, "even_last_octet");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, FD, 1, 1, "even_eop_t");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, F7, 1, 1, "even_eop_r1");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, BC, 1, 0, "even_idle_k");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, D50, 0, 0, "even_idle_d");

    // Frame whose first octet would land odd: dropped, /S/ replaces the second
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin ef = BC; ek = 1; eb = 0; end
      else if (i == 1) begin ef = D50; ek = 0; eb = 0; end
      else if (i == 2) begin ef = FB; ek = 1; eb = 1; end
      else begin ef = oct[i-1]; ek = 0; eb = 1; end
      applyStimulus(1, 1, 0, 1, oct[i], 0, ef, ek, eb, "odd_start");
    end
    applyStimulus(1, 1, 0, 0, 8'h00, 0, 8'hA2, 0, 1, "odd_last_octet");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, FD, 1, 1, "odd_eop_t");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, F7, 1, 1, "odd_eop_r1");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, F7, 1, 1, "odd_eop_r2");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, BC, 1, 0, "odd_idle_k");

    // Error propagation, ignored carrier extension, disparity-selected idle
    applyStimulus(1, 1, 0, 1, 8'h55, 0, D50, 0, 0, "err_idle_d");
    applyStimulus(1, 1, 0, 1, 8'hD5, 0, FB, 1, 1, "err_sop");
    applyStimulus(1, 1, 0, 1, 8'h11, 0, 8'hD5, 0, 1, "err_data1");
    applyStimulus(1, 1, 0, 1, 8'h22, 1, 8'h11, 0, 1, "err_data2");
    applyStimulus(1, 1, 0, 1, 8'h33, 0, FE, 1, 1, "err_data3_v");
    applyStimulus(1, 1, 0, 0, 8'h00, 1, 8'h33, 0, 1, "err_data4");
    applyStimulus(1, 1, 0, 0, 8'h00, 1, FD, 1, 1, "err_eop_t_ext");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, F7, 1, 1, "err_eop_r1");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, F7, 1, 1, "err_eop_r2");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, BC, 1, 0, "err_idle_k");
    applyStimulus(1, 1, 1, 0, 8'h00, 0, C5, 0, 0, "idle_d_rd_pos");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, BC, 1, 0, "rd_idle_k");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, D50, 0, 0, "rd_idle_d");

    // Configuration sets, SGMII word passed through
    tx_config_reg = 16'h01A0;
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0, 8'h00, 0, cfg_a[i], cfg_k[i], 0, "cfg_sgmii");
    applyStimulus(1, 0, 0, 0, 8'h00, 0, BC, 1, 0, "cfg_repeat_c1");
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 8'hB5, 0, 0, "cfg_repeat_b5");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, 8'hA0, 0, 0, "cfg_xmit_ignored");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, 8'h01, 0, 0, "cfg_set_completes");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, BC, 1, 0, "cfg_exit_idle_k");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, D50, 0, 0, "cfg_exit_idle_d");

    // Bit 0 of the config word differs between the SGMII and 1000BASE-X instances
    tx_config_reg = 16'h0021;
    for (int i = 0; i < 8; i++)
      driveStep(1, 0, 0, 0, 8'h00, 0, 1'b1, cfg_b0[i], cfg_b1[i], cfg_k[i], 0, "cfg_bit0");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, BC, 1, 0, "cfg_c2_exit_idle_k");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, D50, 0, 0, "cfg_c2_exit_idle_d");

    // Autoneg leaves data mode mid-frame: /T/, /R/, then config; tx_en ignored in config
    applyStimulus(1, 1, 0, 0, 8'h00, 0, BC, 1, 0, "drop_idle_k");
    applyStimulus(1, 1, 0, 1, 8'h55, 0, D50, 0, 0, "drop_idle_d");
    applyStimulus(1, 1, 0, 1, 8'h66, 0, FB, 1, 1, "drop_sop");
    applyStimulus(1, 1, 0, 1, 8'h77, 0, 8'h66, 0, 1, "drop_data");
    applyStimulus(1, 0, 0, 1, 8'h88, 0, FD, 1, 1, "drop_eop_t");
    applyStimulus(1, 0, 0, 1, 8'h99, 0, F7, 1, 1, "drop_eop_r1");
    applyStimulus(1, 0, 0, 1, 8'hAA, 0, BC, 1, 0, "drop_cfg_k");
    applyStimulus(1, 0, 0, 1, 8'hBB, 0, 8'hB5, 0, 0, "drop_cfg_b5");
    driveStep(1, 1, 0, 0, 8'h00, 0, 1'b1, 8'h21, 8'h20, 0, 0, "drop_cfg_lo");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, "drop_cfg_hi");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, BC, 1, 0, "drop_idle_k2");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, D50, 0, 0, "drop_idle_d2");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, BC, 1, 0, "drop_idle_k3");

    // Asynchronous reset in the middle of a frame
    applyStimulus(1, 1, 0, 1, 8'h55, 0, D50, 0, 0, "rst_idle_d");
    applyStimulus(1, 1, 0, 1, 8'h12, 0, FB, 1, 1, "rst_sop");
    applyStimulus(1, 1, 0, 1, 8'h34, 0, 8'h12, 0, 1, "rst_data1");
    driveStep(1, 1, 0, 1, 8'h56, 0, 1'b0, 8'h00, 8'h00, 0, 0, "rst_unchecked");
    assertResetNow();
    applyStimulus(1, 1, 0, 0, 8'h00, 0, D50, 0, 0, "post_reset_idle_d");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, BC, 1, 0, "post_reset_idle_k");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, D50, 0, 0, "post_reset_idle_d2");
    applyStimulus(1, 1, 0, 0, 8'h00, 0, BC, 1, 0, "post_reset_idle_k2");

    for (int w = 0; w < 6 && (q0.size() != 0 || q1.size() != 0); w++) begin
      @(negedge clk);
      #1;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      vec_count++;
      err_count++;
      $display("[TB] FAIL drain: %0d/%0d expectations left unchecked, required 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
